fpu_issue_arbiter: RTL
======================

Name: fpu_issue_arbiter

Overview:
- Shares one external FPU datapath (add/sub/mul/div over NX-exponent/NM-mantissa IEEE754 words) between NREQ requesters.
- Grants requests round-robin and issues at most one operation per cycle.
- Tracks in-flight operations with a LAT-deep valid/ID delay line and routes each result back to its originating requester.
- Holds off further issue while a non-pipelined divide occupies the unit.

Parameters:
- NX, 8, exponent width
- NM, 23, mantissa width; word width N = NX+NM+1
- NREQ, 4, number of requesters (2..16)
- LAT, 3, FPU result latency in cycles from fpu_start (>=1), all ops
- DIV_BUSY, 6, cycles the unit is occupied by a divide, counting the issue cycle (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid; held until granted
- req_op  in  2*NREQ  op per requester, slice i = [2i+1:2i]; 0 add, 1 sub, 2 mul, 3 div
- req_a  in  N*NREQ  operand A per requester, slice i
- req_b  in  N*NREQ  operand B per requester, slice i
- req_ready  out  NREQ  one-hot grant pulse; request accepted this cycle
- fpu_start  out  1  issue strobe to FPU
- fpu_op  out  2  issued op
- fpu_a  out  N  issued operand A
- fpu_b  out  N  issued operand B
- fpu_result  in  N  FPU result, valid LAT cycles after the matching fpu_start
- rsp_valid  out  NREQ  one-hot result strobe
- rsp_id  out  IDW  requester index of the result; IDW = max(1, clog2(NREQ))
- rsp_data  out  N  result word (registered copy of fpu_result)
- busy  out  1  high while any operation is in flight or the divide lockout is active

Behaviour:
- Reset (async assert, sync release): req_ready=0, fpu_start=0, fpu_op/fpu_a/fpu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, rr_ptr=NREQ-1, delay line cleared, state=ISSUE, div counter=0.
- req_ready is combinational from req_valid, state and rr_ptr. All other outputs are registered.
- States:
  - ISSUE: can_issue=1.
  - DIVWAIT: can_issue=0; down-counter loaded with DIV_BUSY-1.
- Transitions:
  - ISSUE -> DIVWAIT when a div is granted and DIV_BUSY>1.
  - DIVWAIT -> ISSUE when the counter reaches 1, so the issue window reopens exactly DIV_BUSY cycles after the div grant.
- Arbitration (ISSUE only): search requesters in order rr_ptr+1, rr_ptr+2, ... mod NREQ; the first with req_valid=1 gets req_ready=1. On grant, rr_ptr <= granted index. With no requests, rr_ptr is unchanged.
- Issue timing: in the cycle after a grant, fpu_start=1 and fpu_op/fpu_a/fpu_b carry the granted request's fields. fpu_start is a single-cycle pulse. Issue data registers hold their last values when idle.
- Delay line: LAT+1 stages of {valid, id}. Stage 0 is written with {1, id} on fpu_start. When the last stage is valid:
  - rsp_valid[id] <= 1;
  - rsp_id <= id;
  - rsp_data <= fpu_result sampled exactly LAT cycles after fpu_start.
  - Total request-to-response latency = LAT+2 cycles from the grant edge.
- Results return in issue order. There is no response backpressure; requesters must sink rsp every cycle.
- Back-to-back: grants may occur on consecutive cycles (throughput 1/cycle for add/sub/mul). A div grant blocks all grants for the following DIV_BUSY-1 cycles.
- Requesters whose req_valid drops before grant are simply skipped. No grant is given to a deasserted request.
- busy = (state==DIVWAIT) | any delay-line stage valid | fpu_start.
- Reset mid-operation: all in-flight entries are discarded with no rsp_valid, and the lockout is cancelled.
- NREQ=1: arbiter degenerates to req_ready = req_valid & can_issue; rr_ptr stays 0.
- The block performs no operand checking; NaN/Inf/zero handling is entirely the FPU's.

Test Plan:
- Single add, NX=8/NM=23, LAT=3: req0 op=0, a=0x3F800000, b=0x40000000; FPU model returns 0x40400000 -> req_ready[0] at cycle 0, fpu_start at cycle 1, rsp_valid[0]=1 with rsp_id=0 and rsp_data=0x40400000 at cycle 5.
- Round-robin fairness: all 4 req_valid held high with mul ops -> grants cycle through 0,1,2,3,0,... one per cycle; responses return in the same ID order, LAT+2 cycles after each grant.
- Divide lockout, DIV_BUSY=6: req1 div (0x40400000/0x3F800000) while req2 waits with add -> req2 is granted exactly 6 cycles after the req1 grant; busy stays high throughout.
- Withdrawn request: req3 valid for 1 cycle while req0 is being granted, then dropped -> req3 never gets req_ready, and no rsp_valid[3] ever appears.
- Reset mid-flight: issue 3 back-to-back adds, assert rst_n=0 one cycle after the third grant -> all outputs 0 immediately; no rsp_valid after release; first grant after release goes to requester 0.
- DIV_BUSY=1 boundary: consecutive div grants from req0 and req1 on adjacent cycles -> no lockout; both responses arrive on adjacent cycles, in order.

Source files
------------

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter that shares one fixed-latency FPU between NREQ requesters.
// A delay line of {valid, id} steers each result back to its originator; a divide locks out issue.
module fpu_issue_arbiter #(
  parameter  int NX       = 8,
  parameter  int NM       = 23,
  parameter  int NREQ     = 4,
  parameter  int LAT      = 3,
  parameter  int DIV_BUSY = 6,
  localparam int N        = NX + NM + 1,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [N*NREQ-1:0] req_a,
  input  logic [N*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              fpu_start,
  output logic [1:0]        fpu_op,
  output logic [N-1:0]      fpu_a,
  output logic [N-1:0]      fpu_b,
  input  logic [N-1:0]      fpu_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  output logic              busy
);

  localparam int CW = $clog2(DIV_BUSY + 1);

  typedef enum logic {ISSUE, DIVWAIT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IDW-1:0]         rr_ptr_q;
  logic                   fpu_start_q;
  logic [1:0]             fpu_op_q;
  logic [N-1:0]           fpu_a_q, fpu_b_q;
  logic [LAT:0]           dl_vld_q;
  logic [LAT:0][IDW-1:0]  dl_id_q;
  logic [NREQ-1:0]        rsp_valid_q;
  logic [IDW-1:0]         rsp_id_q;
  logic [N-1:0]           rsp_data_q;
  logic                   busy_q, busy_d;

  logic                   gnt_any;
  logic [IDW-1:0]         gnt_idx, cand;
  logic [1:0]             sel_op;
  logic [N-1:0]           sel_a, sel_b;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    if (state_q == ISSUE) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDW'((32'(rr_ptr_q) + 32'(k)) % NREQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[N*i +: N];
        sel_b  = req_b[N*i +: N];
      end
    end
  end

  // Counter is loaded with DIV_BUSY-1 so issue reopens DIV_BUSY cycles after the div grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ISSUE: begin
        if (gnt_any && sel_op == 2'd3 && DIV_BUSY > 1) begin
          state_d = DIVWAIT;
          cnt_d   = CW'(DIV_BUSY - 1);
        end
      end
      DIVWAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ISSUE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered busy reflects lockout, in-flight stages and the issue strobe of the coming cycle.
  assign busy_d = (state_d == DIVWAIT) | (|dl_vld_q[LAT-1:0]) | gnt_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ISSUE;
      cnt_q       <= '0;
      rr_ptr_q    <= IDW'(NREQ - 1);
      fpu_start_q <= 1'b0;
      fpu_op_q    <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      dl_vld_q    <= '0;
      dl_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fpu_start_q <= gnt_any;
      if (gnt_any) begin
        rr_ptr_q <= gnt_idx;
        fpu_op_q <= sel_op;
        fpu_a_q  <= sel_a;
        fpu_b_q  <= sel_b;
      end
      // Stage 0 lines up with fpu_start; stage LAT lines up with the valid fpu_result.
      dl_vld_q <= {dl_vld_q[LAT-1:0], gnt_any};
      dl_id_q  <= {dl_id_q[LAT-1:0], gnt_idx};
      if (dl_vld_q[LAT]) begin
        rsp_valid_q <= NREQ'(1) << dl_id_q[LAT];
        rsp_id_q    <= dl_id_q[LAT];
        rsp_data_q  <= fpu_result;
      end else begin
        rsp_valid_q <= '0;
      end
      busy_q <= busy_d;
    end
  end

  assign fpu_start = fpu_start_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule
